// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES key schedule generator, one word per clock
//
// Expands a 128/192/256-bit cipher key (NK = 4/6/8 words) into the full
// round-key schedule.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   start       expand key_in; only looked at while idle
//   key_in      cipher key, MSB-aligned (word 0 in [255:224])
//   busy        expansion in progress
//   done        one-cycle pulse after the last schedule word is written
//   keys_valid  round_keys holds a complete schedule for the last accepted key
//   round_keys  round key r in [128*r +: 128], w[4r] in its MSBs
module aes_key_expander #(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [255:0]          key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic [128*(NR+1)-1:0] round_keys
);

  localparam int IW = $clog2(NW);

  // Forward S-box, entry b at [2047-8*b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_w [NW];
  logic [IW-1:0]   r_i;
  // r_kidx tracks i mod NK so NK = 6 needs no divider.
  logic [2:0]      r_kidx;
  logic [7:0]      r_rcon;
  logic            r_done;
  logic            r_valid;

  logic [IW-1:0]   w_prev_idx;
  logic [IW-1:0]   w_back_idx;
  logic [31:0]     w_prev;
  logic [31:0]     w_back;
  logic [31:0]     w_sub;
  logic [31:0]     w_temp;
  logic [31:0]     w_new;
  logic            w_last;
  logic            w_kidx_zero;

  assign w_prev_idx  = r_i - IW'(1);
  assign w_back_idx  = r_i - IW'(NK);
  assign w_prev      = r_w[w_prev_idx];
  assign w_back      = r_w[w_back_idx];
  assign w_kidx_zero = (r_kidx == 3'd0);
  // RotWord only applies on the Rcon step; the NK=8 mid step substitutes unrotated.
  assign w_sub       = sub_word(w_kidx_zero ? {w_prev[23:0], w_prev[31:24]} : w_prev);
  assign w_new       = w_back ^ w_temp;
  assign w_last      = (r_i == IW'(NW - 1));

  always_comb begin
    w_temp = w_prev;
    if (w_kidx_zero) begin
      w_temp = w_sub ^ {r_rcon, 24'h000000};
    end else if (NK == 8 && r_kidx == 3'd4) begin
      w_temp = w_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)  w_state_next = S_EXPAND;
      S_EXPAND: if (w_last) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        r_w[k] <= 32'h0;
      end
      r_i     <= '0;
      r_kidx  <= 3'd0;
      r_rcon  <= 8'h01;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) begin
              r_w[k] <= key_in[255 - 32*k -: 32];
            end
            r_valid <= 1'b0;
            r_i     <= IW'(NK);
            r_kidx  <= 3'd0;
            r_rcon  <= 8'h01;
          end
        end
        S_EXPAND: begin
          r_w[r_i] <= w_new;
          r_i      <= r_i + IW'(1);
          r_kidx   <= (r_kidx == 3'(NK - 1)) ? 3'd0 : r_kidx + 3'd1;
          if (w_kidx_zero) begin
            // xtime: multiply by x in GF(2^8)
            r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
          end
          if (w_last) begin
            r_done  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_EXPAND);
  assign done       = r_done;
  assign keys_valid = r_valid;

  for (genvar j = 0; j < NW; j++) begin : g_map
    assign round_keys[32*(4*(j/4) + 3 - (j%4)) +: 32] = r_w[j];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed FIPS-197 vector bench for aes_key_expander
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst;
  logic s4, s6, s8;
  logic [255:0] k4, k6, k8;
  logic b4, b6, b8, d4, d6, d8, v4, v6, v8;
  logic [1407:0] rk4;
  logic [1663:0] rk6;
  logic [1919:0] rk8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] KEY_A  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_B  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_6  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hdeadbeefcafef00d};
  localparam logic [255:0] KEY_8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK4_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_expander #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4), .key_in(k4),
    .busy(b4), .done(d4), .keys_valid(v4), .round_keys(rk4)
  );
  aes_key_expander #(.NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(s6), .key_in(k6),
    .busy(b6), .done(d6), .keys_valid(v6), .round_keys(rk6)
  );
  aes_key_expander #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .key_in(k8),
    .busy(b8), .done(d8), .keys_valid(v8), .round_keys(rk8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 4) ? d4 : (sel == 6) ? d6 : d8;
  endfunction

  // Pulses start for one accept edge, then counts edges until done (bounded).
  task automatic run(input int sel, input logic [255:0] key, output int n, output logic busy_seen);
    case (sel)
      4: begin k4 = key; s4 = 1'b1; end
      6: begin k6 = key; s6 = 1'b1; end
      default: begin k8 = key; s8 = 1'b1; end
    endcase
    tick();
    busy_seen = (sel == 4) ? b4 : (sel == 6) ? b6 : b8;
    s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
    k4 = '1;   k6 = '1;   k8 = '1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_of(sel) && n < 200);
  endtask

  initial begin
    int n, cnt, first;
    int edges[3];
    int mism;
    logic bs;

    rst = 1'b1;
    s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
    k4 = '0;   k6 = '0;   k8 = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", {b4, b6, b8}, 3'b000);
    check("rst_done", {d4, d6, d8}, 3'b000);
    check("rst_valid", {v4, v6, v8}, 3'b000);
    check("rst_rk_zero", {|rk4, |rk6, |rk8}, 3'b000);

    // NK=4 FIPS-197 A.1
    run(4, KEY_A, n, bs);
    check("nk4_busy_after_accept", bs, 1'b1);
    check("nk4_latency", n, 40);
    check("nk4_valid", v4, 1'b1);
    check("nk4_busy_at_done", b4, 1'b0);
    check("nk4_round0", rk4[127:0], KEY_A[255:128]);
    check("nk4_w4", rk4[128+96 +: 32], 32'ha0fafe17);
    check("nk4_round1", rk4[128 +: 128], RK4_1);
    check("nk4_round10", rk4[1280 +: 128], RK4_10);
    tick();
    check("nk4_done_pulse_width", d4, 1'b0);

    // Idle: key_in changes without start must not disturb the schedule.
    k4 = KEY_B;
    repeat (5) tick();
    check("idle_hold_round10", rk4[1280 +: 128], RK4_10);
    check("idle_hold_round0", rk4[127:0], KEY_A[255:128]);
    check("idle_hold_valid", v4, 1'b1);

    // NK=6 FIPS-197 A.2, junk in ignored low key bits
    run(6, KEY_6, n, bs);
    check("nk6_latency", n, 46);
    check("nk6_valid", v6, 1'b1);
    check("nk6_w6", rk6[160 +: 32], 32'hfe0c91f7);
    check("nk6_w51", rk6[128*12 +: 32], 32'h01002202);

    // NK=8 FIPS-197 A.3
    run(8, KEY_8, n, bs);
    check("nk8_latency", n, 52);
    check("nk8_valid", v8, 1'b1);
    check("nk8_w8", rk8[352 +: 32], 32'h9ba35411);
    check("nk8_w12", rk8[480 +: 32], 32'ha8b09c1a);
    check("nk8_w59", rk8[128*14 +: 32], 32'h706c631e);

    // Second start at edge 10 of an expansion is ignored.
    k4 = KEY_A; s4 = 1'b1;
    tick();
    s4 = 1'b0;
    cnt = 0; first = -1;
    for (int e = 1; e <= 100; e++) begin
      if (e == 10) begin s4 = 1'b1; k4 = KEY_B; end
      else s4 = 1'b0;
      tick();
      if (d4) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    s4 = 1'b0;
    check("busy_start_latency", first, 40);
    check("busy_start_done_count", cnt, 1);
    check("busy_start_round10", rk4[1280 +: 128], RK4_10);

    // Reset at edge 20 aborts the expansion.
    k4 = KEY_A; s4 = 1'b1;
    tick();
    s4 = 1'b0;
    cnt = 0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (d4) cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", b4, 1'b0);
    check("abort_valid", v4, 1'b0);
    check("abort_rk_zero", |rk4, 1'b0);
    for (int e = 0; e < 50; e++) begin
      if (d4 || v4) cnt++;
      tick();
    end
    check("abort_no_done", cnt, 0);
    run(4, KEY_A, n, bs);
    check("abort_restart_latency", n, 40);
    check("abort_restart_round1", rk4[128 +: 128], RK4_1);
    check("abort_restart_round10", rk4[1280 +: 128], RK4_10);

    // start held high: back-to-back expansions
    k4 = KEY_A; s4 = 1'b1;
    cnt = 0; mism = 0;
    for (int e = 1; e <= 130; e++) begin
      tick();
      if (v4 !== d4) mism++;
      if (d4) begin
        if (cnt < 3) edges[cnt] = e;
        cnt++;
      end
    end
    s4 = 1'b0;
    check("b2b_done_count", cnt, 3);
    check("b2b_valid_only_in_done", mism, 0);
    if (cnt >= 3) begin
      check("b2b_spacing_1", edges[1] - edges[0], 41);
      check("b2b_spacing_2", edges[2] - edges[1], 41);
    end else begin
      check("b2b_spacing_timeout", cnt, 3);
    end
    n = 0;
    while (!d4 && n < 200) begin
      tick();
      n++;
    end
    check("b2b_final_round10", rk4[1280 +: 128], RK4_10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
